// File: rtl/core_pkg.sv
// Shared pipeline definitions: register index width, operand-source select
// encoding used by the execute-stage forwarding muxes, and the stage tag record.
package core_pkg;

  localparam int REG_AW = 3;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] SRC_RF       = 2'b00;
  localparam logic [SEL_W-1:0] SRC_PREV_ALU = 2'b01;
  localparam logic [SEL_W-1:0] SRC_PREV_MEM = 2'b10;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] dest;
    logic              wr;
    logic              load;
  } stage_tag_t;

endpackage

// File: rtl/fwd_match.sv
// Per-source comparator: matches one decode source against the EX and MEM
// destination tags and yields the forwarding select plus a load-use hit.
module fwd_match
  import core_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  stage_tag_t        ex_tag,
  input  logic              mem_vld,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wr,
  output logic [SEL_W-1:0]  next_sel,
  output logic              load_hit
);

  logic hit_ex;
  logic hit_mem;

  always_comb begin
    hit_ex   = src_used & ex_tag.vld & ex_tag.wr & (ex_tag.dest == src);
    hit_mem  = src_used & mem_vld & mem_wr & (mem_dest == src);
    load_hit = hit_ex & ex_tag.load;
    // The younger producer (in EX) shadows an older one in MEM.
    if (hit_ex)       next_sel = SRC_PREV_ALU;
    else if (hit_mem) next_sel = SRC_PREV_MEM;
    else              next_sel = SRC_RF;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator between decode and ID/EX.
// FWD_HAZARD_PERF_EN enables the stall/forward performance counters.
module fwd_hazard_unit
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              flush,
  input  logic              hold,
  output logic [SEL_W-1:0]  alu_src1,
  output logic [SEL_W-1:0]  alu_src2,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       fwd_cnt
);

  stage_tag_t        ex_tag;
  logic              mem_vld;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_wr;

  logic [SEL_W-1:0]  next_sel1;
  logic [SEL_W-1:0]  next_sel2;
  logic              load_hit1;
  logic              load_hit2;
  logic              issue;

  fwd_match u_match1 (
    .src      (id_src1),
    .src_used (id_use1),
    .ex_tag   (ex_tag),
    .mem_vld  (mem_vld),
    .mem_dest (mem_dest),
    .mem_wr   (mem_wr),
    .next_sel (next_sel1),
    .load_hit (load_hit1)
  );

  fwd_match u_match2 (
    .src      (id_src2),
    .src_used (id_use2),
    .ex_tag   (ex_tag),
    .mem_vld  (mem_vld),
    .mem_dest (mem_dest),
    .mem_wr   (mem_wr),
    .next_sel (next_sel2),
    .load_hit (load_hit2)
  );

  // An instruction advances into EX only when it is real, not killed and not
  // stalled; hold freezes everything and suppresses the stall output.
  always_comb begin
    stall_id = id_valid & ~flush & ~hold & (load_hit1 | load_hit2);
    issue    = id_valid & ~flush & ~stall_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_tag    <= '0;
      mem_vld   <= 1'b0;
      mem_dest  <= '0;
      mem_wr    <= 1'b0;
      alu_src1  <= SRC_RF;
      alu_src2  <= SRC_RF;
      bubble_ex <= 1'b1;
    end else if (!hold) begin
      mem_vld  <= ex_tag.vld;
      mem_dest <= ex_tag.dest;
      mem_wr   <= ex_tag.wr;
      if (issue) begin
        ex_tag.vld  <= 1'b1;
        ex_tag.dest <= id_dest;
        ex_tag.wr   <= id_wr;
        ex_tag.load <= id_load;
        bubble_ex   <= 1'b0;
        alu_src1    <= next_sel1;
        alu_src2    <= next_sel2;
      end else begin
        ex_tag.vld <= 1'b0;
        bubble_ex  <= 1'b1;
        alu_src1   <= SRC_RF;
        alu_src2   <= SRC_RF;
      end
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] fwd_q;
  logic        fwd_event;

  assign fwd_event = issue & ((next_sel1 != SRC_RF) | (next_sel2 != SRC_RF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      fwd_q   <= '0;
    end else if (!hold) begin
      if (stall_id && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (fwd_event && fwd_q != 16'hFFFF)  fwd_q   <= fwd_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign fwd_cnt   = fwd_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: scenario tasks drive decode-slot vectors, expected
// registered outputs go through a queue and are compared one cycle later.
module tb_fwd_hazard_unit;

`ifdef FWD_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_src1;
  logic [2:0]  id_src2;
  logic        id_use1;
  logic        id_use2;
  logic [2:0]  id_dest;
  logic        id_wr;
  logic        id_load;
  logic        flush;
  logic        hold;
  logic [1:0]  alu_src1;
  logic [1:0]  alu_src2;
  logic        stall_id;
  logic        bubble_ex;
  logic [15:0] stall_cnt;
  logic [15:0] fwd_cnt;

  int total = 0;
  int bad   = 0;
  int exp_sc = 0;
  int exp_fc = 0;

  // expected registered output packed as {bubble_ex, alu_src1, alu_src2}
  logic [4:0] exp_q[$];

  typedef struct {
    logic       v;
    logic [2:0] s1;
    logic       u1;
    logic [2:0] s2;
    logic       u2;
    logic [2:0] d;
    logic       w;
    logic       ld;
    logic       fl;
    logic       hd;
    logic       est;
    logic [4:0] eo;
  } vec_t;

  fwd_hazard_unit dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_src1   (id_src1),
    .id_src2   (id_src2),
    .id_use1   (id_use1),
    .id_use2   (id_use2),
    .id_dest   (id_dest),
    .id_wr     (id_wr),
    .id_load   (id_load),
    .flush     (flush),
    .hold      (hold),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2),
    .stall_id  (stall_id),
    .bubble_ex (bubble_ex),
    .stall_cnt (stall_cnt),
    .fwd_cnt   (fwd_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic v, input logic [2:0] s1, input logic u1,
                              input logic [2:0] s2, input logic u2, input logic [2:0] d,
                              input logic w, input logic ld, input logic fl, input logic hd,
                              input logic est, input logic [4:0] eo);
    vec_t t;
    t.v = v; t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2; t.d = d;
    t.w = w; t.ld = ld; t.fl = fl; t.hd = hd; t.est = est; t.eo = eo;
    return t;
  endfunction

  // driver tasks
  task automatic drive(input vec_t t);
    id_valid = t.v;  id_src1 = t.s1; id_use1 = t.u1;
    id_src2  = t.s2; id_use2 = t.u2; id_dest = t.d;
    id_wr    = t.w;  id_load = t.ld; flush   = t.fl; hold = t.hd;
  endtask

  task automatic bubbles(input int n);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_counts(input vec_t t);
    if (!t.hd && t.est)           exp_sc++;
    if (!t.hd && t.eo[3:0] != 0)  exp_fc++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    #2;
    total++;
    if ({bubble_ex, alu_src1, alu_src2} !== 5'b1_00_00) begin
      bad++; $display("FAIL reset_out got=%b exp=%b", {bubble_ex, alu_src1, alu_src2}, 5'b1_00_00);
    end
    total++;
    if (stall_cnt !== 16'd0 || fwd_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, fwd_cnt);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_chain;
    vec_t tv[$];
    vec_t t;
    logic [4:0] e;
    bubbles(2);
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 5'b0_00_00));
    tv.push_back(mk(1, 1, 1, 5, 1, 6, 1, 0, 0, 0, 0, 5'b0_01_00));
    tv.push_back(mk(1, 6, 0, 1, 1, 7, 1, 0, 0, 0, 0, 5'b0_00_10));
    foreach (tv[i]) begin
      t = tv[i];
      drive(t);
      @(negedge clk);
      total++;
      if (stall_id !== t.est) begin
        bad++; $display("FAIL alu_chain_stall[%0d] got=%b exp=%b", i, stall_id, t.est);
      end
      exp_q.push_back(t.eo);
      model_counts(t);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({bubble_ex, alu_src1, alu_src2} !== e) begin
        bad++; $display("FAIL alu_chain_out[%0d] got=%b exp=%b", i, {bubble_ex, alu_src1, alu_src2}, e);
      end
    end
    total++;
    if (fwd_cnt !== (PERF ? 16'(exp_fc) : 16'd0)) begin
      bad++; $display("FAIL alu_chain_fwd_cnt got=%0d exp=%0d", fwd_cnt, PERF ? exp_fc : 0);
    end
  endtask

  task automatic test_distance2;
    vec_t tv[$];
    vec_t t;
    logic [4:0] e;
    bubbles(2);
    tv.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 5'b0_00_00));
    tv.push_back(mk(1, 6, 1, 7, 1, 5, 1, 0, 0, 0, 0, 5'b0_00_00));
    tv.push_back(mk(1, 3, 1, 2, 1, 4, 1, 0, 0, 0, 0, 5'b0_00_10));
    tv.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 5'b0_00_00));
    tv.push_back(mk(1, 3, 1, 0, 0, 1, 1, 0, 0, 0, 0, 5'b0_00_00));
    foreach (tv[i]) begin
      t = tv[i];
      drive(t);
      @(negedge clk);
      total++;
      if (stall_id !== t.est) begin
        bad++; $display("FAIL distance2_stall[%0d] got=%b exp=%b", i, stall_id, t.est);
      end
      exp_q.push_back(t.eo);
      model_counts(t);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({bubble_ex, alu_src1, alu_src2} !== e) begin
        bad++; $display("FAIL distance2_out[%0d] got=%b exp=%b", i, {bubble_ex, alu_src1, alu_src2}, e);
      end
    end
  endtask

  task automatic test_load_use;
    vec_t tv[$];
    vec_t t;
    logic [4:0] e;
    bubbles(2);
    tv.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 5'b0_00_00));
    tv.push_back(mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 1, 5'b1_00_00));
    tv.push_back(mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0, 5'b0_10_10));
    tv.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 5'b0_00_00));
    tv.push_back(mk(1, 5, 0, 2, 1, 6, 1, 0, 0, 0, 0, 5'b0_00_00));
    foreach (tv[i]) begin
      t = tv[i];
      drive(t);
      @(negedge clk);
      total++;
      if (stall_id !== t.est) begin
        bad++; $display("FAIL load_use_stall[%0d] got=%b exp=%b", i, stall_id, t.est);
      end
      exp_q.push_back(t.eo);
      model_counts(t);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({bubble_ex, alu_src1, alu_src2} !== e) begin
        bad++; $display("FAIL load_use_out[%0d] got=%b exp=%b", i, {bubble_ex, alu_src1, alu_src2}, e);
      end
    end
    total++;
    if (stall_cnt !== (PERF ? 16'(exp_sc) : 16'd0)) begin
      bad++; $display("FAIL load_use_stall_cnt got=%0d exp=%0d", stall_cnt, PERF ? exp_sc : 0);
    end
  endtask

  task automatic test_priority;
    vec_t tv[$];
    vec_t t;
    logic [4:0] e;
    bubbles(2);
    tv.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 5'b0_00_00));
    tv.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 5'b0_00_00));
    tv.push_back(mk(1, 4, 1, 4, 1, 1, 1, 0, 0, 0, 0, 5'b0_01_01));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b0_00_00));
    tv.push_back(mk(1, 4, 1, 0, 1, 2, 1, 0, 0, 0, 0, 5'b0_00_01));
    foreach (tv[i]) begin
      t = tv[i];
      drive(t);
      @(negedge clk);
      total++;
      if (stall_id !== t.est) begin
        bad++; $display("FAIL priority_stall[%0d] got=%b exp=%b", i, stall_id, t.est);
      end
      exp_q.push_back(t.eo);
      model_counts(t);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({bubble_ex, alu_src1, alu_src2} !== e) begin
        bad++; $display("FAIL priority_out[%0d] got=%b exp=%b", i, {bubble_ex, alu_src1, alu_src2}, e);
      end
    end
  endtask

  task automatic test_flush_hold;
    vec_t tv[$];
    vec_t t;
    logic [4:0] e;
    logic [15:0] sc_hold;
    logic [15:0] fc_hold;
    bubbles(2);
    tv.push_back(mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 5'b0_00_00));
    tv.push_back(mk(1, 6, 1, 0, 0, 7, 1, 1, 1, 0, 0, 5'b1_00_00));
    tv.push_back(mk(1, 6, 1, 0, 0, 7, 1, 1, 0, 0, 0, 5'b0_10_00));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(1, 7, 1, 0, 0, 2, 1, 0, 0, 1, 0, 5'b0_10_00));
    tv.push_back(mk(1, 7, 1, 0, 0, 2, 1, 0, 0, 0, 1, 5'b1_00_00));
    tv.push_back(mk(1, 7, 1, 0, 0, 2, 1, 0, 0, 0, 0, 5'b0_10_00));
    sc_hold = '0;
    fc_hold = '0;
    foreach (tv[i]) begin
      t = tv[i];
      drive(t);
      if (i == 3) begin
        sc_hold = stall_cnt;
        fc_hold = fwd_cnt;
      end
      @(negedge clk);
      total++;
      if (stall_id !== t.est) begin
        bad++; $display("FAIL flush_hold_stall[%0d] got=%b exp=%b", i, stall_id, t.est);
      end
      exp_q.push_back(t.eo);
      model_counts(t);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if ({bubble_ex, alu_src1, alu_src2} !== e) begin
        bad++; $display("FAIL flush_hold_out[%0d] got=%b exp=%b", i, {bubble_ex, alu_src1, alu_src2}, e);
      end
      if (i == 5) begin
        total++;
        if (stall_cnt !== sc_hold || fwd_cnt !== fc_hold) begin
          bad++; $display("FAIL hold_cnt_frozen got=%0d/%0d exp=%0d/%0d", stall_cnt, fwd_cnt, sc_hold, fc_hold);
        end
      end
    end
    total++;
    if (stall_cnt !== (PERF ? 16'(exp_sc) : 16'd0) || fwd_cnt !== (PERF ? 16'(exp_fc) : 16'd0)) begin
      bad++; $display("FAIL flush_hold_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, fwd_cnt,
                      PERF ? exp_sc : 0, PERF ? exp_fc : 0);
    end
  endtask

  task automatic test_reset_mid_stall;
    logic [4:0] e;
    bubbles(2);
    drive(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 5'b0));
    @(posedge clk); #1;
    drive(mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 1, 5'b0));
    @(negedge clk);
    total++;
    if (stall_id !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre_stall got=%b exp=1", stall_id);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bubble_ex, alu_src1, alu_src2, stall_id} !== 6'b1_00_00_0) begin
      bad++; $display("FAIL rst_mid_async got=%b exp=%b", {bubble_ex, alu_src1, alu_src2, stall_id}, 6'b1_00_00_0);
    end
    total++;
    if (stall_cnt !== 16'd0 || fwd_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_mid_cnt got=%0d/%0d exp=0/0", stall_cnt, fwd_cnt);
    end
    exp_sc = 0;
    exp_fc = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (stall_id !== 1'b0) begin
      bad++; $display("FAIL rst_mid_post_stall got=%b exp=0", stall_id);
    end
    exp_q.push_back(5'b0_00_00);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if ({bubble_ex, alu_src1, alu_src2} !== e) begin
      bad++; $display("FAIL rst_mid_consumer got=%b exp=%b", {bubble_ex, alu_src1, alu_src2}, e);
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_distance2();
    test_load_use();
    test_priority();
    test_flush_hold();
    test_reset_mid_stall();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
